ram_burst_master: RTL and testbench

- Initiator-side controller for the team's synchronous single-port RAM (chip-select / write-enable / output-enable interface with registered read data).
- Accepts burst read or write requests on a valid/ready command channel and streams write data in over a valid/ready channel.
- Sequences one RAM access per cycle and returns read data on a response stream with a last-beat flag.
- Sits between testbench or agent logic and the RAM, replacing hand-driven RAM pins.

---
 rtl/ram_burst_master_if.sv | 56 +++++
 rtl/ram_burst_master.sv | 148 ++++++++++++++
 tb/tb_ram_burst_master.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_master_if.sv
// Command/stream side and RAM pin side bundles for ram_burst_master.
// The master modport is the initiator of each bundle.
interface ram_burst_master_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  wd_valid;
  logic                  wd_ready;
  logic [DATA_WIDTH-1:0] wd_data;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_last;
  logic                  busy;

  modport master (
    output req_valid, req_we, req_addr, req_len,
    output wd_valid, wd_data,
    input  req_ready, wd_ready,
    input  rsp_valid, rsp_rdata, rsp_last, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_len,
    input  wd_valid, wd_data,
    output req_ready, wd_ready,
    output rsp_valid, rsp_rdata, rsp_last, busy
  );
endinterface

interface ram_bus_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  ram_cs;
  logic                  ram_we;
  logic                  ram_oe;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport master (
    output ram_cs, ram_we, ram_oe, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport slave (
    input  ram_cs, ram_we, ram_oe, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/ram_burst_master.sv
// Burst controller for the synchronous single-port RAM: one access per
// cycle, registered pins, fixed 2-cycle read command-to-response latency.
module ram_burst_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 4
) (
  input logic clk,
  input logic rst_n,
  ram_burst_master_if.slave host,
  ram_bus_if.master         ram
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rdl_q, rdl_d;

  logic                  p1v_q, p1l_q;
  logic                  rv_q, rl_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  rd_issue;
  logic                  cnt_zero;

  assign rd_issue = cs_q & oe_q & ~we_q;
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    oe_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdl_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (host.req_valid) begin
          cur_d   = host.req_addr;
          cnt_d   = host.req_len;
          state_d = host.req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        if (host.wd_valid) begin
          cs_d    = 1'b1;
          we_d    = 1'b1;
          addr_d  = cur_q;
          wdata_d = host.wd_data;
          cur_d   = cur_q + ADDR_WIDTH'(1);
          if (cnt_zero) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - LEN_WIDTH'(1);
          end
        end
      end
      READ: begin
        cs_d   = 1'b1;
        oe_d   = 1'b1;
        addr_d = cur_q;
        cur_d  = cur_q + ADDR_WIDTH'(1);
        if (cnt_zero) begin
          rdl_d   = 1'b1;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q - LEN_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (rv_q && rl_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdl_q   <= rdl_d;
    end
  end

  // Stage 1 marks the cycle the RAM presents data; stage 2 is the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1v_q   <= 1'b0;
      p1l_q   <= 1'b0;
      rv_q    <= 1'b0;
      rl_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      p1v_q <= rd_issue;
      p1l_q <= rd_issue & rdl_q;
      rv_q  <= p1v_q;
      rl_q  <= p1l_q;
      if (p1v_q) rdata_q <= ram.ram_rdata;
    end
  end

  assign host.req_ready = rst_n & (state_q == IDLE);
  assign host.wd_ready  = (state_q == WRITE);
  assign host.busy      = (state_q != IDLE);
  assign host.rsp_valid = rv_q;
  assign host.rsp_last  = rl_q;
  assign host.rsp_rdata = rdata_q;

  assign ram.ram_cs    = cs_q;
  assign ram.ram_we    = we_q;
  assign ram.ram_oe    = oe_q;
  assign ram.ram_addr  = addr_q;
  assign ram.ram_wdata = wdata_q;

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed and randomized bursts against a behavioural RAM and a flat
// memory reference model; every comparison is an immediate assertion.
module tb_ram_burst_master;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int LW    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ram_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) hif ();
  ram_bus_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_burst_master #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .host (hif.slave),
    .ram  (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM with registered read data, Z when not reading
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] rd_q;
  logic          rd_en = 1'b0;
  always @(posedge clk) begin
    rd_en <= 1'b0;
    if (bus.ram_cs === 1'b1 && bus.ram_we === 1'b1) begin
      ram_mem[bus.ram_addr] = bus.ram_wdata;
    end else if (bus.ram_cs === 1'b1 && bus.ram_oe === 1'b1) begin
      rd_q  <= ram_mem[bus.ram_addr];
      rd_en <= 1'b1;
    end
  end
  assign bus.ram_rdata = rd_en ? rd_q : 'z;

  typedef struct {
    int          t;
    logic        we;
    logic        oe;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } pin_t;
  typedef struct {
    int          t;
    logic [DW-1:0] d;
    logic        l;
  } rsp_t;

  pin_t pins[$];
  rsp_t rsps[$];

  always @(negedge clk) begin
    if (bus.ram_cs === 1'b1)
      pins.push_back('{cyc, bus.ram_we, bus.ram_oe, bus.ram_addr, bus.ram_wdata});
    if (hif.rsp_valid === 1'b1)
      rsps.push_back('{cyc, hif.rsp_rdata, hif.rsp_last});
  end

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] wbeats[$];
  int            wgaps[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_req(logic we, logic [AW-1:0] a, logic [LW-1:0] l);
    int n = 0;
    hif.req_valid = 1'b1;
    hif.req_we    = we;
    hif.req_addr  = a;
    hif.req_len   = l;
    while (hif.req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept", {31'd0, hif.req_ready}, 1);
    @(negedge clk);
    hif.req_valid = 1'b0;
  endtask

  task automatic send_wdata();
    int n;
    foreach (wbeats[i]) begin
      hif.wd_valid = 1'b0;
      repeat (wgaps[i]) begin
        @(negedge clk);
        chk("busy_in_gap", {31'd0, hif.busy}, 1);
      end
      hif.wd_valid = 1'b1;
      hif.wd_data  = wbeats[i];
      n = 0;
      while (hif.wd_ready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
    end
    hif.wd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (hif.busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", {31'd0, hif.busy}, 0);
    tick(3);
  endtask

  task automatic write_burst(logic [AW-1:0] a, logic [LW-1:0] l);
    int nb = int'(l) + 1;
    pins.delete();
    rsps.delete();
    send_req(1'b1, a, l);
    send_wdata();
    wait_idle();
    for (int i = 0; i < nb; i++) ref_mem[(int'(a) + i) % DEPTH] = wbeats[i];
    chk("wr_pin_count", pins.size(), nb);
    for (int i = 0; i < nb && i < pins.size(); i++) begin
      chk("wr_addr", pins[i].a, (int'(a) + i) % DEPTH);
      chk("wr_data", pins[i].d, wbeats[i]);
      chk("wr_we_oe", {30'd0, pins[i].we, pins[i].oe}, 2);
      if (i > 0) chk("wr_spacing", pins[i].t - pins[i-1].t, wgaps[i] + 1);
    end
    chk("wr_no_rsp", rsps.size(), 0);
  endtask

  task automatic read_burst(logic [AW-1:0] a, logic [LW-1:0] l);
    int nb = int'(l) + 1;
    pins.delete();
    rsps.delete();
    send_req(1'b0, a, l);
    wait_idle();
    chk("rd_pin_count", pins.size(), nb);
    chk("rd_rsp_count", rsps.size(), nb);
    for (int i = 0; i < nb && i < pins.size(); i++) begin
      chk("rd_addr", pins[i].a, (int'(a) + i) % DEPTH);
      chk("rd_we_oe", {30'd0, pins[i].we, pins[i].oe}, 1);
      chk("rd_issue_contig", pins[i].t - pins[0].t, i);
    end
    for (int i = 0; i < nb && i < rsps.size(); i++) begin
      chk("rd_data", rsps[i].d, ref_mem[(int'(a) + i) % DEPTH]);
      chk("rd_last", {31'd0, rsps[i].l}, (i == nb - 1) ? 1 : 0);
      if (i < pins.size()) chk("rd_latency", rsps[i].t - pins[i].t, 2);
    end
  endtask

  function automatic logic [31:0] out_or();
    return {hif.rsp_valid, hif.rsp_last, hif.rsp_rdata, bus.ram_cs,
            bus.ram_we, bus.ram_oe, bus.ram_addr, bus.ram_wdata,
            hif.busy, hif.wd_ready, hif.req_ready};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    int n;
    int wr_seen;
    logic [AW-1:0] ra;
    logic [LW-1:0] rl;

    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = DW'($urandom);
      ram_mem[i] = ref_mem[i];
    end
    hif.req_valid = 1'b0;
    hif.req_we    = 1'b0;
    hif.req_addr  = '0;
    hif.req_len   = '0;
    hif.wd_valid  = 1'b0;
    hif.wd_data   = '0;

    tick(3);
    chk("reset_outputs", out_or(), 0);
    rst_n = 1'b1;
    #1;
    chk("reset_req_ready", {31'd0, hif.req_ready}, 1);
    tick(1);

    // Contiguous write then read-back
    wbeats = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    wgaps  = '{0, 0, 0, 0};
    write_burst(4'd2, 4'd3);
    read_burst(4'd2, 4'd3);

    // Address wrap
    wbeats = '{8'h11, 8'h22, 8'h33, 8'h44};
    wgaps  = '{0, 0, 0, 0};
    write_burst(4'd14, 4'd3);
    read_burst(4'd15, 4'd1);

    // Write data stall: valid pattern 1,0,0,1
    wbeats = '{8'hC5, 8'h3C};
    wgaps  = '{0, 2};
    write_burst(4'd6, 4'd1);

    // Request presented while a read burst is running
    pins.delete();
    rsps.delete();
    send_req(1'b0, 4'd0, 4'd7);
    hif.req_valid = 1'b1;
    hif.req_we    = 1'b1;
    hif.req_addr  = 4'd5;
    hif.req_len   = 4'd0;
    bad = 0;
    n = 0;
    while (hif.busy === 1'b1 && n < 100) begin
      if (hif.req_ready !== 1'b0) bad++;
      @(negedge clk);
      n++;
    end
    hif.req_valid = 1'b0;
    chk("ready_low_while_busy", bad, 0);
    chk("busy_rsp_count", rsps.size(), 8);
    tick(5);
    chk("busy_req_dropped", {31'd0, hif.busy}, 0);
    wr_seen = 0;
    foreach (pins[i]) if (pins[i].we === 1'b1) wr_seen++;
    chk("busy_no_write", wr_seen, 0);
    for (int i = 0; i < 8 && i < rsps.size(); i++)
      chk("busy_rd_data", rsps[i].d, ref_mem[i]);

    // Single-beat read and full-length read
    wbeats = '{8'h5A};
    wgaps  = '{0};
    write_burst(4'd9, 4'd0);
    read_burst(4'd9, 4'd0);
    read_burst(4'd3, 4'd15);

    // Asynchronous reset in the middle of a read
    pins.delete();
    rsps.delete();
    send_req(1'b0, 4'd0, 4'd7);
    tick(5);
    #2;
    chk("pre_reset_rsp", {31'd0, hif.rsp_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", out_or(), 0);
    tick(2);
    rst_n = 1'b1;
    pins.delete();
    rsps.delete();
    #1;
    chk("post_reset_ready", {31'd0, hif.req_ready}, 1);
    tick(6);
    chk("post_reset_no_rsp", rsps.size(), 0);
    chk("post_reset_no_ram", pins.size(), 0);
    read_burst(4'd0, 4'd7);

    // Randomized write/read pairs
    for (int k = 0; k < 6; k++) begin
      ra = AW'($urandom);
      rl = LW'($urandom);
      wbeats.delete();
      wgaps.delete();
      for (int i = 0; i <= int'(rl); i++) begin
        wbeats.push_back(DW'($urandom));
        wgaps.push_back(int'($urandom_range(0, 2)));
      end
      write_burst(ra, rl);
      read_burst(AW'($urandom), LW'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
